// File: rtl/decode_stage.sv
// Decode stage: register file, MIPS-subset decoder, ID-stage branch/jump
// resolution with fetch redirect, and the ID/EX pipeline register.
module decode_stage #(
   parameter int NREGS = 32
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ex_id_stall,
   input  logic [31:0] if_id_instruc,
   input  logic [31:0] if_id_nextpc,
   input  logic        wb_id_regwrite,
   input  logic [4:0]  wb_id_regdest,
   input  logic [31:0] wb_id_writedata,
   output logic        id_if_selpcsource,
   output logic [1:0]  id_if_selpctype,
   output logic [31:0] id_if_pcimd2ext,
   output logic [31:0] id_if_rega,
   output logic [31:0] id_if_pcindex,
   output logic [31:0] id_ex_rega,
   output logic [31:0] id_ex_regb,
   output logic [31:0] id_ex_imedext,
   output logic [4:0]  id_ex_regdest,
   output logic [4:0]  id_ex_shamt,
   output logic [2:0]  id_ex_aluop,
   output logic        id_ex_alusrc,
   output logic        id_ex_memread,
   output logic        id_ex_memwrite,
   output logic        id_ex_regwrite
);

   localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND = 3'b010;
   localparam logic [2:0] OR  = 3'b011, SLT = 3'b100, SLL = 3'b101;
   localparam logic [2:0] SRL = 3'b110, PASSB = 3'b111;

   typedef enum logic {RUN, SHADOW} state_t;

   state_t      r_state, w_state_nxt;
   logic [31:0] r_regs [NREGS];

   logic [5:0]  w_opc, w_funct;
   logic [4:0]  w_rs, w_rt, w_rd_f, w_sh_f;
   logic [15:0] w_imm16;
   logic [31:0] w_sext, w_zext;
   logic [31:0] w_rs_val, w_rt_val;
   logic        w_wb_en;

   logic        w_valid, w_redir;
   logic [1:0]  w_type;
   logic [31:0] w_ra, w_rb, w_imm;
   logic [4:0]  w_rd, w_sh;
   logic [2:0]  w_aluop;
   logic        w_src, w_mr, w_mw, w_rw;
   logic        w_bubble;

   assign w_opc   = if_id_instruc[31:26];
   assign w_rs    = if_id_instruc[25:21];
   assign w_rt    = if_id_instruc[20:16];
   assign w_rd_f  = if_id_instruc[15:11];
   assign w_sh_f  = if_id_instruc[10:6];
   assign w_funct = if_id_instruc[5:0];
   assign w_imm16 = if_id_instruc[15:0];
   assign w_sext  = {{16{w_imm16[15]}}, w_imm16};
   assign w_zext  = {16'h0, w_imm16};

   // write-first bypass so a value retiring this cycle is seen by ID
   assign w_wb_en  = wb_id_regwrite && (wb_id_regdest != 5'd0);
   assign w_rs_val = (w_wb_en && wb_id_regdest == w_rs) ? wb_id_writedata
                   : (w_rs == 5'd0) ? 32'h0 : r_regs[w_rs];
   assign w_rt_val = (w_wb_en && wb_id_regdest == w_rt) ? wb_id_writedata
                   : (w_rt == 5'd0) ? 32'h0 : r_regs[w_rt];

   always_comb begin
      w_valid = 1'b0;
      w_redir = 1'b0;
      w_type  = 2'b00;
      w_ra    = w_rs_val;
      w_rb    = w_rt_val;
      w_imm   = 32'h0;
      w_rd    = 5'd0;
      w_sh    = 5'd0;
      w_aluop = ADD;
      w_src   = 1'b0;
      w_mr    = 1'b0;
      w_mw    = 1'b0;
      w_rw    = 1'b0;
      case (w_opc)
         6'h00: begin
            w_rd = w_rd_f;
            w_rw = 1'b1;
            w_valid = 1'b1;
            case (w_funct)
               6'h20: w_aluop = ADD;
               6'h22: w_aluop = SUB;
               6'h24: w_aluop = AND;
               6'h25: w_aluop = OR;
               6'h2A: w_aluop = SLT;
               6'h00: begin w_aluop = SLL; w_sh = w_sh_f; end
               6'h02: begin w_aluop = SRL; w_sh = w_sh_f; end
               6'h08: begin w_valid = 1'b0; w_redir = 1'b1; w_type = 2'b01; end
               6'h0C: begin w_valid = 1'b0; w_redir = 1'b1; w_type = 2'b11; end
               default: w_valid = 1'b0;
            endcase
         end
         6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B: begin
            w_valid = 1'b1;
            w_rd    = w_rt;
            w_src   = 1'b1;
            w_rw    = 1'b1;
            w_imm   = w_sext;
            case (w_opc)
               6'h0C: begin w_aluop = AND; w_imm = w_zext; end
               6'h0D: begin w_aluop = OR;  w_imm = w_zext; end
               6'h0F: begin w_aluop = PASSB; w_imm = {w_imm16, 16'h0}; end
               6'h23: w_mr = 1'b1;
               6'h2B: begin w_mw = 1'b1; w_rw = 1'b0; end
               default: w_aluop = ADD;
            endcase
         end
         6'h04: w_redir = (w_rs_val == w_rt_val);
         6'h05: w_redir = (w_rs_val != w_rt_val);
         6'h02: begin w_redir = 1'b1; w_type = 2'b10; end
         6'h03: begin
            w_redir = 1'b1;
            w_type  = 2'b10;
            w_valid = 1'b1;
            w_rd    = 5'd31;
            w_ra    = 32'h0;
            w_rb    = 32'h0;
            w_imm   = if_id_nextpc;
            w_src   = 1'b1;
            w_rw    = 1'b1;
         end
         default: w_valid = 1'b0;
      endcase
      if (if_id_instruc == 32'h0) w_valid = 1'b0;
   end

   assign id_if_selpcsource = w_redir && !ex_id_stall && (r_state == RUN);
   assign id_if_selpctype   = w_type;
   assign id_if_pcimd2ext   = if_id_nextpc + {w_sext[29:0], 2'b00};
   assign id_if_rega        = w_rs_val;
   assign id_if_pcindex     = {if_id_nextpc[31:28], if_id_instruc[25:0], 2'b00};

   // SHADOW holds the wrong-path instruction fetched behind a redirect
   always_comb begin
      w_state_nxt = r_state;
      if (!ex_id_stall) begin
         if (r_state == SHADOW) w_state_nxt = RUN;
         else if (w_redir)      w_state_nxt = SHADOW;
      end
   end

   assign w_bubble = (r_state == SHADOW) || !w_valid;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) r_regs[i] <= 32'h0;
      end else if (w_wb_en) begin
         r_regs[wb_id_regdest] <= wb_id_writedata;
      end
   end

   always_ff @(posedge clock) begin
      if (reset || (!ex_id_stall && w_bubble)) begin
         id_ex_rega     <= 32'h0;
         id_ex_regb     <= 32'h0;
         id_ex_imedext  <= 32'h0;
         id_ex_regdest  <= 5'd0;
         id_ex_shamt    <= 5'd0;
         id_ex_aluop    <= 3'b000;
         id_ex_alusrc   <= 1'b0;
         id_ex_memread  <= 1'b0;
         id_ex_memwrite <= 1'b0;
         id_ex_regwrite <= 1'b0;
      end else if (!ex_id_stall) begin
         id_ex_rega     <= w_ra;
         id_ex_regb     <= w_rb;
         id_ex_imedext  <= w_imm;
         id_ex_regdest  <= w_rd;
         id_ex_shamt    <= w_sh;
         id_ex_aluop    <= w_aluop;
         id_ex_alusrc   <= w_src;
         id_ex_memread  <= w_mr;
         id_ex_memwrite <= w_mw;
         id_ex_regwrite <= w_rw;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: expected ID/EX bundles are queued as each
// instruction is driven and checked after the clock edge that registers them.
module tb_decode_stage;

   logic        clock = 1'b0;
   logic        reset;
   logic        ex_id_stall;
   logic [31:0] if_id_instruc, if_id_nextpc;
   logic        wb_id_regwrite;
   logic [4:0]  wb_id_regdest;
   logic [31:0] wb_id_writedata;
   logic        id_if_selpcsource;
   logic [1:0]  id_if_selpctype;
   logic [31:0] id_if_pcimd2ext, id_if_rega, id_if_pcindex;
   logic [31:0] id_ex_rega, id_ex_regb, id_ex_imedext;
   logic [4:0]  id_ex_regdest, id_ex_shamt;
   logic [2:0]  id_ex_aluop;
   logic        id_ex_alusrc, id_ex_memread, id_ex_memwrite, id_ex_regwrite;

   typedef struct packed {
      logic [31:0] ra;
      logic [31:0] rb;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic [4:0]  sh;
      logic [2:0]  op;
      logic        src;
      logic        mr;
      logic        mw;
      logic        rw;
   } ex_t;

   localparam ex_t BUB = '0;

   ex_t q[$];
   int  checks = 0;
   int  errors = 0;

   always #5 clock = ~clock;

   decode_stage dut (
      .clock(clock), .reset(reset), .ex_id_stall(ex_id_stall),
      .if_id_instruc(if_id_instruc), .if_id_nextpc(if_id_nextpc),
      .wb_id_regwrite(wb_id_regwrite), .wb_id_regdest(wb_id_regdest),
      .wb_id_writedata(wb_id_writedata),
      .id_if_selpcsource(id_if_selpcsource), .id_if_selpctype(id_if_selpctype),
      .id_if_pcimd2ext(id_if_pcimd2ext), .id_if_rega(id_if_rega),
      .id_if_pcindex(id_if_pcindex),
      .id_ex_rega(id_ex_rega), .id_ex_regb(id_ex_regb),
      .id_ex_imedext(id_ex_imedext), .id_ex_regdest(id_ex_regdest),
      .id_ex_shamt(id_ex_shamt), .id_ex_aluop(id_ex_aluop),
      .id_ex_alusrc(id_ex_alusrc), .id_ex_memread(id_ex_memread),
      .id_ex_memwrite(id_ex_memwrite), .id_ex_regwrite(id_ex_regwrite)
   );

   function automatic ex_t mk(input logic [31:0] ra, rb, imm,
                              input logic [4:0] rd, sh, input logic [2:0] op,
                              input logic src, mr, mw, rw);
      ex_t e;
      e.ra = ra; e.rb = rb; e.imm = imm; e.rd = rd; e.sh = sh;
      e.op = op; e.src = src; e.mr = mr; e.mw = mw; e.rw = rw;
      return e;
   endfunction

   task automatic drv(input logic rst, stall, input logic [31:0] ins, pc,
                      input logic wbe, input logic [4:0] wbd,
                      input logic [31:0] wbv, input ex_t exp);
      reset = rst; ex_id_stall = stall;
      if_id_instruc = ins; if_id_nextpc = pc;
      wb_id_regwrite = wbe; wb_id_regdest = wbd; wb_id_writedata = wbv;
      q.push_back(exp);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input string tag);
      ex_t obs, exp;
      @(posedge clock);
      #1;
      obs = mk(id_ex_rega, id_ex_regb, id_ex_imedext, id_ex_regdest,
               id_ex_shamt, id_ex_aluop, id_ex_alusrc, id_ex_memread,
               id_ex_memwrite, id_ex_regwrite);
      checks++;
      if (q.size() == 0) begin
         errors++;
         $error("FAIL %s scoreboard empty observed=%h", tag, obs);
      end else begin
         exp = q.pop_front();
         assert (obs === exp)
         else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
         end
      end
   endtask

   initial begin
      drv(1, 0, 32'h0, 32'h0, 0, 0, 0, BUB);
      cyc("reset");

      drv(0, 0, 32'h20010005, 32'h4, 0, 0, 0,
          mk(0, 0, 5, 1, 0, 3'b000, 1, 0, 0, 1));
      chk("addi_noredir", id_if_selpcsource, 0);
      cyc("addi");

      drv(0, 0, 32'h00401820, 32'h8, 1, 2, 32'hDEADBEEF,
          mk(32'hDEADBEEF, 0, 0, 3, 0, 3'b000, 0, 0, 0, 1));
      chk("bypass_rega", id_if_rega, 32'hDEADBEEF);
      cyc("add_bypass");

      drv(0, 0, 32'h00022825, 32'hC, 1, 0, 32'h1234,
          mk(0, 32'hDEADBEEF, 0, 5, 0, 3'b011, 0, 0, 0, 1));
      cyc("or_r0_write_ignored");

      drv(0, 0, 32'h0, 32'h10, 1, 4, 7, BUB);
      cyc("nop_w4");
      drv(0, 0, 32'h0, 32'h14, 1, 5, 7, BUB);
      cyc("nop_w5");

      drv(0, 0, 32'h10850003, 32'h104, 0, 0, 0, BUB);
      chk("beq_sel", id_if_selpcsource, 1);
      chk("beq_type", id_if_selpctype, 2'b00);
      chk("beq_target", id_if_pcimd2ext, 32'h110);
      cyc("beq_bubble");

      drv(0, 0, 32'h08000010, 32'h108, 0, 0, 0, BUB);
      chk("shadow_suppress", id_if_selpcsource, 0);
      cyc("shadow_bubble");

      drv(0, 0, 32'h0C000040, 32'h20, 0, 0, 0,
          mk(0, 0, 32'h20, 31, 0, 3'b000, 1, 0, 0, 1));
      chk("jal_sel", id_if_selpcsource, 1);
      chk("jal_type", id_if_selpctype, 2'b10);
      chk("jal_index", id_if_pcindex, 32'h100);
      cyc("jal_link");

      drv(0, 0, 32'h20010005, 32'h24, 1, 31, 32'h80, BUB);
      cyc("jal_shadow");

      drv(0, 0, 32'h0000000C, 32'h28, 0, 0, 0, BUB);
      chk("sys_sel", id_if_selpcsource, 1);
      chk("sys_type", id_if_selpctype, 2'b11);
      cyc("sys_bubble");
      drv(0, 0, 32'h0, 32'h44, 0, 0, 0, BUB);
      cyc("sys_shadow");

      drv(0, 0, 32'h03E00008, 32'h48, 0, 0, 0, BUB);
      chk("jr_sel", id_if_selpcsource, 1);
      chk("jr_type", id_if_selpctype, 2'b01);
      chk("jr_rega", id_if_rega, 32'h80);
      cyc("jr_bubble");
      drv(0, 0, 32'h0, 32'h84, 0, 0, 0, BUB);
      cyc("jr_shadow");

      drv(0, 0, 32'h14850003, 32'h88, 0, 0, 0, BUB);
      chk("bne_not_taken", id_if_selpcsource, 0);
      cyc("bne_bubble");

      drv(0, 0, 32'h3C091234, 32'h8C, 0, 0, 0,
          mk(0, 0, 32'h12340000, 9, 0, 3'b111, 1, 0, 0, 1));
      cyc("lui");
      drv(0, 0, 32'hAC02FFFC, 32'h90, 0, 0, 0,
          mk(0, 32'hDEADBEEF, 32'hFFFFFFFC, 2, 0, 3'b000, 1, 0, 1, 0));
      cyc("sw_sext");
      drv(0, 0, 32'h00025102, 32'h94, 0, 0, 0,
          mk(0, 32'hDEADBEEF, 0, 10, 4, 3'b110, 0, 0, 0, 1));
      cyc("srl");

      drv(0, 0, 32'h8C460008, 32'h98, 0, 0, 0,
          mk(32'hDEADBEEF, 0, 8, 6, 0, 3'b000, 1, 1, 0, 1));
      cyc("lw");
      drv(0, 1, 32'h10850003, 32'h104, 1, 7, 32'h55,
          mk(32'hDEADBEEF, 0, 8, 6, 0, 3'b000, 1, 1, 0, 1));
      chk("stall_noredir1", id_if_selpcsource, 0);
      cyc("stall_hold1");
      drv(0, 1, 32'h10850003, 32'h104, 0, 0, 0,
          mk(32'hDEADBEEF, 0, 8, 6, 0, 3'b000, 1, 1, 0, 1));
      chk("stall_noredir2", id_if_selpcsource, 0);
      cyc("stall_hold2");
      drv(0, 0, 32'h00E04025, 32'h9C, 0, 0, 0,
          mk(32'h55, 0, 0, 8, 0, 3'b011, 0, 0, 0, 1));
      cyc("write_during_stall");

      drv(0, 0, 32'h10850003, 32'h104, 0, 0, 0, BUB);
      chk("beq2_sel", id_if_selpcsource, 1);
      cyc("beq2_bubble");
      drv(1, 1, 32'h20010005, 32'h108, 0, 0, 0, BUB);
      cyc("reset_in_shadow");
      drv(0, 0, 32'h08000010, 32'h44, 0, 0, 0, BUB);
      chk("run_after_reset", id_if_selpcsource, 1);
      chk("j_index", id_if_pcindex, 32'h40);
      cyc("j_bubble");
      drv(0, 0, 32'h0, 32'h48, 0, 0, 0, BUB);
      cyc("j_shadow");
      drv(0, 0, 32'h00401820, 32'h4C, 0, 0, 0,
          mk(0, 0, 0, 3, 0, 3'b000, 0, 0, 0, 1));
      cyc("regs_cleared");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule
